mdu_hilo: RTL and testbench
===========================

MDU_HILO -- requirements
Module: mdu_hilo

Interface
REQ-001 Parameter: W, default 32, operand and HI/LO width (even, >=8).
REQ-002 Parameter: MUL_CYCLES, default 2, multiplier latency in cycles (>=1).
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 op_valid  input  1  operation request.
REQ-006 op_ready  output  1  unit can accept an op; equals state==IDLE.
REQ-007 op_code  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB.
REQ-008 src_a  input  W  rs operand (dividend / multiplicand / MTHI-MTLO data).
REQ-009 src_b  input  W  rt operand (divisor / multiplier).
REQ-010 cancel  input  1  abort in-flight op (exception flush).
REQ-011 busy  output  1  state!=IDLE.
REQ-012 done  output  1  registered one-cycle pulse; new HI/LO visible the same cycle.
REQ-013 div_by_zero  output  1  pulses with done when a DIV/DIVU had src_b==0.
REQ-014 hi  output  W  HI register.
REQ-015 lo  output  W  LO register.

Function
REQ-016 Acceptance: op_valid&&op_ready&&!cancel at a rising edge; this is cycle 0; operands and op_code are latched at that edge.
REQ-017 FSM states IDLE, MUL, DIV; IDLE->MUL on MULT/MULTU/MADD/MSUB, IDLE->DIV on DIV/DIVU, MTHI/MTLO stay in IDLE.
REQ-018 MTHI/MTLO: hi (resp. lo) <= src_a at acceptance edge; done high in cycle 1; other register unchanged.
REQ-019 MUL: 2W-bit product (signed for MULT/MADD/MSUB, unsigned for MULTU); stays MUL for MUL_CYCLES cycles; {hi,lo} written and done high in cycle MUL_CYCLES+1.
REQ-020 DIV: radix-2 restoring on magnitudes, one bit per cycle, W cycles in DIV; lo<=quotient, hi<=remainder, done high in cycle W+1.
REQ-021 Signed division truncates toward zero; remainder takes dividend's sign; most-negative / -1 gives lo=most-negative, hi=0.
REQ-022 Divide by zero: lo=all ones (unsigned) / per algorithm with sign fix (signed), hi=src_a; div_by_zero=1 with done; no hang.
REQ-023 op_ready high in the done cycle; back-to-back op accepted there, no bubble.
REQ-024 cancel in MUL/DIV: state->IDLE next edge, hi/lo unchanged, no done, no div_by_zero.
REQ-025 cancel with op_valid in IDLE: op dropped; cancel outranks acceptance.
REQ-026 op_valid while busy is ignored (not queued).

Reset
REQ-027 rst forces state=IDLE, hi=0, lo=0, done=0, div_by_zero=0, counters=0; rst outranks cancel and op_valid.
REQ-028 rst mid-operation discards the op; no done afterwards.

Configuration
REQ-029 Macro MDU_MADD_EN: when defined, MADD does {hi,lo}<={hi,lo}+signed product and MSUB {hi,lo}<={hi,lo}-signed product (mod 2^2W), same latency as MULT.
REQ-030 Without MDU_MADD_EN, op 110/111 accepted, stay IDLE, done high in cycle 1, hi/lo unchanged; no accumulate logic synthesized.

Verification (W=32, MUL_CYCLES=2)
REQ-031 MULT a=0xFFFFFFFF b=2 -> done cycle 3, hi=0xFFFFFFFF lo=0xFFFFFFFE; MULTU same -> hi=0x00000001 lo=0xFFFFFFFE.
REQ-032 DIVU a=100 b=7 -> done cycle 33, lo=14 hi=2; DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
REQ-033 DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0; DIVU a=5 b=0 -> div_by_zero=1, lo=0xFFFFFFFF hi=5.
REQ-034 DIVU accepted, cancel in cycle 10 -> busy=0 in cycle 11, hi/lo keep prior values, no done in cycles 11-40.
REQ-035 MTHI 0x1234 then MTLO 0x5678 back-to-back -> done cycles 1 and 2, hi=0x1234 lo=0x5678; MULT accepted in MULT's done cycle -> second done 3 cycles later.
REQ-036 With MDU_MADD_EN: hi=0 lo=0xFFFFFFFF, MADD a=1 b=1 -> hi=1 lo=0; MSUB a=1 b=1 -> hi=0 lo=0xFFFFFFFF.

Source files
------------

// File: rtl/mdu_hilo.sv
// mdu_hilo: MIPS-style multiply/divide unit with HI/LO result registers.
// Multiply takes MUL_CYCLES cycles; divide is radix-2 restoring, one quotient bit per cycle.
// Optional feature macro MDU_MADD_EN enables the MADD/MSUB accumulate into {HI,LO}.
module mdu_hilo #(
    parameter int W          = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [2:0]   op_code,
    input  logic [W-1:0] src_a,
    input  logic [W-1:0] src_b,
    input  logic         cancel,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    localparam int CNT_MAX = (W > MUL_CYCLES) ? W : MUL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [W-1:0]       r_hi, r_lo;
    logic               r_done, r_dbz;

    // Latched operands and divider working registers
    logic [W-1:0]       r_a, r_b;
    logic               r_sgn;
    logic [W-1:0]       r_quo, r_rem, r_dvs;
    logic               r_neg_q, r_neg_r, r_dz;
`ifdef MDU_MADD_EN
    logic               r_acc, r_sub;
`endif

    logic               w_accept, w_is_mul, w_is_div, w_sgn;
    logic               w_mul_last, w_div_last;
    logic [2*W-1:0]     w_ma, w_mb, w_prod, w_mul_res;
    logic [W:0]         w_rem_sh, w_trial;
    logic               w_qbit;
    logic [W-1:0]       w_rem_nxt, w_quo_nxt, w_q_fin, w_r_fin;

    // Magnitude of a value, treated as two's complement only when sgn is set
    function automatic logic [W-1:0] f_mag(input logic [W-1:0] v, input logic sgn);
        return (sgn && v[W-1]) ? -v : v;
    endfunction

    assign op_ready    = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

    assign w_accept   = op_valid && (r_state == IDLE) && !cancel;
    assign w_is_div   = (op_code == OP_DIV) || (op_code == OP_DIVU);
`ifdef MDU_MADD_EN
    assign w_is_mul   = (op_code == OP_MULT) || (op_code == OP_MULTU) ||
                        (op_code == OP_MADD) || (op_code == OP_MSUB);
`else
    assign w_is_mul   = (op_code == OP_MULT) || (op_code == OP_MULTU);
`endif
    // MADD/MSUB are signed; otherwise bit 0 selects the unsigned variant
    assign w_sgn      = op_code[2] | ~op_code[0];
    assign w_mul_last = (r_state == MUL) && (r_cnt == CNT_W'(MUL_CYCLES - 1));
    assign w_div_last = (r_state == DIV) && (r_cnt == CNT_W'(W - 1));

    // Low 2W bits of the product are the same for signed and unsigned once operands are extended
    assign w_ma   = {{W{r_sgn & r_a[W-1]}}, r_a};
    assign w_mb   = {{W{r_sgn & r_b[W-1]}}, r_b};
    assign w_prod = w_ma * w_mb;
`ifdef MDU_MADD_EN
    assign w_mul_res = !r_acc ? w_prod :
                       (r_sub ? ({r_hi, r_lo} - w_prod) : ({r_hi, r_lo} + w_prod));
`else
    assign w_mul_res = w_prod;
`endif

    // One restoring step: shift in the next dividend bit, subtract if it fits
    assign w_rem_sh  = {r_rem, r_quo[W-1]};
    assign w_trial   = w_rem_sh - {1'b0, r_dvs};
    assign w_qbit    = ~w_trial[W];
    assign w_rem_nxt = w_qbit ? w_trial[W-1:0] : w_rem_sh[W-1:0];
    assign w_quo_nxt = {r_quo[W-2:0], w_qbit};
    assign w_q_fin   = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_r_fin   = r_neg_r ? -w_rem_nxt : w_rem_nxt;

    // Next-state logic; cancel returns a busy unit to IDLE without a result
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) begin
                if (w_is_mul)      w_state_nxt = MUL;
                else if (w_is_div) w_state_nxt = DIV;
            end
            MUL:  if (cancel || w_mul_last) w_state_nxt = IDLE;
            DIV:  if (cancel || w_div_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Cycle counter, restarts on every state change
    always_ff @(posedge clk) begin
        if (rst)                        r_cnt <= '0;
        else if (w_state_nxt != r_state) r_cnt <= '0;
        else if (r_state != IDLE)        r_cnt <= r_cnt + CNT_W'(1);
    end

    // Operand capture at acceptance and divider iteration
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a     <= src_a;
            r_b     <= src_b;
            r_sgn   <= w_sgn;
            r_quo   <= f_mag(src_a, w_sgn);
            r_dvs   <= f_mag(src_b, w_sgn);
            r_rem   <= '0;
            r_neg_q <= w_sgn & (src_a[W-1] ^ src_b[W-1]);
            r_neg_r <= w_sgn & src_a[W-1];
            r_dz    <= (src_b == '0);
`ifdef MDU_MADD_EN
            r_acc   <= op_code[2];
            r_sub   <= op_code[0];
`endif
        end else if (r_state == DIV) begin
            r_quo <= w_quo_nxt;
            r_rem <= w_rem_nxt;
        end
    end

    // HI/LO update and the one-cycle done / div_by_zero pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                IDLE: if (w_accept) begin
                    case (op_code)
                        OP_MTHI: begin r_hi <= src_a; r_done <= 1'b1; end
                        OP_MTLO: begin r_lo <= src_a; r_done <= 1'b1; end
`ifndef MDU_MADD_EN
                        OP_MADD, OP_MSUB: r_done <= 1'b1;
`endif
                        default: ;
                    endcase
                end
                MUL: if (!cancel && w_mul_last) begin
                    {r_hi, r_lo} <= w_mul_res;
                    r_done       <= 1'b1;
                end
                DIV: if (!cancel && w_div_last) begin
                    r_lo   <= w_q_fin;
                    r_hi   <= w_r_fin;
                    r_done <= 1'b1;
                    r_dbz  <= r_dz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Testbench for mdu_hilo (W=32, MUL_CYCLES=2): directed table, corner-case sequences,
// and random operations checked against an arithmetic reference model.
module tb_mdu_hilo;
    localparam int W  = 32;
    localparam int MC = 2;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [2:0]    op_code = 3'b000;
    logic [W-1:0]  src_a = '0;
    logic [W-1:0]  src_b = '0;
    logic          cancel = 1'b0;
    logic          busy, done, div_by_zero;
    logic [W-1:0]  hi, lo;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    mdu_hilo #(.W(W), .MUL_CYCLES(MC)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .src_a(src_a), .src_b(src_b), .cancel(cancel),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t tbl[11];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one op, wait (bounded) for done, then check latency and results
    task automatic run_vec(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                           input logic edz, input int elat);
        int lat;
        op_valid = 1'b1; op_code = op; src_a = a; src_b = b;
        tick;
        op_valid = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            tick;
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(elat));
        chk({tag, " hi"}, 64'(hi), 64'(ehi));
        chk({tag, " lo"}, 64'(lo), 64'(elo));
        chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(edz));
    endtask

    // Reference model: results from plain integer arithmetic on the architectural rules
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ch, input logic [31:0] cl,
                         output logic [31:0] eh, output logic [31:0] el,
                         output logic edz, output int elat);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eh = ch; el = cl; edz = 1'b0; elat = 1;
        case (op)
            OP_MULT:  begin p = sa * sb; {eh, el} = p; elat = MC + 1; end
            OP_MULTU: begin p = 64'(a) * 64'(b); {eh, el} = p; elat = MC + 1; end
            OP_DIV, OP_DIVU: begin
                elat = W + 1;
                if (b == 0) begin
                    edz = 1'b1;
                    eh  = a;
                    el  = (op == OP_DIV && sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
                end else if (op == OP_DIV) begin
                    q = sa / sb; r = sa % sb;
                    el = 32'(q); eh = 32'(r);
                end else begin
                    el = a / b; eh = a % b;
                end
            end
            OP_MTHI: eh = a;
            OP_MTLO: el = a;
            default: begin
`ifdef MDU_MADD_EN
                p = sa * sb;
                {eh, el} = (op == OP_MADD) ? ({ch, cl} + p) : ({ch, cl} - p);
                elat = MC + 1;
`endif
            end
        endcase
    endtask

    initial begin
        logic [31:0] eh, el;
        logic        edz;
        int          elat, lat;
        logic        seen;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        tbl[0]  = '{OP_MULT,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 3};
        tbl[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 3};
        tbl[2]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33};
        tbl[3]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
        tbl[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 33};
        tbl[5]  = '{OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 33};
        tbl[6]  = '{OP_MTHI,  32'h1234,      32'd0,         32'h1234,      32'hFFFF_FFFF, 1'b0, 1};
        tbl[7]  = '{OP_MTLO,  32'h5678,      32'd0,         32'h1234,      32'h5678,      1'b0, 1};
        tbl[8]  = '{OP_DIV,   32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 1'b1, 33};
        tbl[9]  = '{OP_DIV,   32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'd1,         1'b1, 33};
        tbl[10] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0, 3};

        // Reset state
        repeat (3) tick;
        rst = 1'b0;
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset dbz", 64'(div_by_zero), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset ready", 64'(op_ready), 64'd1);

        // Directed table
        for (int i = 0; i < 11; i++)
            run_vec($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                    tbl[i].hi, tbl[i].lo, tbl[i].dz, tbl[i].lat);

        // Back-to-back MTHI/MTLO, then MULT issued in a MULT done cycle
        tick;
        op_valid = 1'b1; op_code = OP_MTHI; src_a = 32'h1111;
        tick;
        chk("b2b mthi done", 64'(done), 64'd1);
        chk("b2b mthi hi", 64'(hi), 64'h1111);
        op_code = OP_MTLO; src_a = 32'h2222;
        tick;
        op_valid = 1'b0;
        chk("b2b mtlo done", 64'(done), 64'd1);
        chk("b2b mtlo lo", 64'(lo), 64'h2222);
        chk("b2b mtlo hi kept", 64'(hi), 64'h1111);
        op_valid = 1'b1; op_code = OP_MULT; src_a = 32'd3; src_b = 32'd5;
        tick;
        op_valid = 1'b0;
        tick; tick;
        chk("mult1 done cyc3", 64'(done), 64'd1);
        chk("mult1 lo", 64'(lo), 64'd15);
        chk("mult1 ready", 64'(op_ready), 64'd1);
        op_valid = 1'b1; src_a = 32'hFFFF_FFFE; src_b = 32'd3;
        tick;
        op_valid = 1'b0;
        chk("mult2 no done c1", 64'(done), 64'd0);
        tick;
        chk("mult2 no done c2", 64'(done), 64'd0);
        tick;
        chk("mult2 done c3", 64'(done), 64'd1);
        chk("mult2 hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

        // Cancel a DIVU in cycle 10
        run_vec("setup mthi", OP_MTHI, 32'hAAAA, 32'd0, 32'hAAAA, 32'hFFFF_FFFA, 1'b0, 1);
        run_vec("setup mtlo", OP_MTLO, 32'hBBBB, 32'd0, 32'hAAAA, 32'hBBBB, 1'b0, 1);
        op_valid = 1'b1; op_code = OP_DIVU; src_a = 32'd1000; src_b = 32'd3;
        tick;
        op_valid = 1'b0;
        repeat (9) tick;
        chk("cancel busy c10", 64'(busy), 64'd1);
        cancel = 1'b1;
        tick;
        cancel = 1'b0;
        chk("cancel busy c11", 64'(busy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done || div_by_zero) seen = 1'b1;
            tick;
        end
        chk("cancel no done", 64'(seen), 64'd0);
        chk("cancel hi kept", 64'(hi), 64'hAAAA);
        chk("cancel lo kept", 64'(lo), 64'hBBBB);

        // Cancel in IDLE drops the request
        op_valid = 1'b1; cancel = 1'b1; op_code = OP_MTHI; src_a = 32'hDEAD;
        tick;
        op_valid = 1'b0; cancel = 1'b0;
        chk("idle cancel done", 64'(done), 64'd0);
        chk("idle cancel busy", 64'(busy), 64'd0);
        tick;
        chk("idle cancel hi", 64'(hi), 64'hAAAA);

        // Requests while busy are ignored
        op_valid = 1'b1; op_code = OP_DIVU; src_a = 32'd50; src_b = 32'd5;
        tick;
        op_code = OP_MTHI; src_a = 32'h7777;
        repeat (10) tick;
        op_valid = 1'b0;
        lat = 11;
        while (!done && lat < 100) begin tick; lat++; end
        chk("busy-ign latency", 64'(lat), 64'd33);
        chk("busy-ign lo", 64'(lo), 64'd10);
        chk("busy-ign hi", 64'(hi), 64'd0);
        tick; tick;
        chk("busy-ign hi later", 64'(hi), 64'd0);

        // Accumulate ops
`ifdef MDU_MADD_EN
        run_vec("madd setup hi", OP_MTHI, 32'd0, 32'd0, 32'd0, 32'd10, 1'b0, 1);
        run_vec("madd setup lo", OP_MTLO, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
        run_vec("madd", OP_MADD, 32'd1, 32'd1, 32'd1, 32'd0, 1'b0, 3);
        run_vec("msub", OP_MSUB, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 3);
`else
        run_vec("madd off", OP_MADD, 32'd1, 32'd1, 32'd0, 32'd10, 1'b0, 1);
        run_vec("msub off", OP_MSUB, 32'd9, 32'd9, 32'd0, 32'd10, 1'b0, 1);
`endif

        // Reset mid-operation
        op_valid = 1'b1; op_code = OP_DIV; src_a = 32'd100; src_b = 32'd7;
        tick;
        op_valid = 1'b0;
        repeat (4) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst mid hi", 64'(hi), 64'd0);
        chk("rst mid lo", 64'(lo), 64'd0);
        chk("rst mid busy", 64'(busy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen = 1'b1;
            tick;
        end
        chk("rst mid no done", 64'(seen), 64'd0);

        // Random operations against the reference model
        m_hi = 32'd0; m_lo = 32'd0;
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
            model(rop, ra, rb, m_hi, m_lo, eh, el, edz, elat);
            run_vec($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, eh, el, edz, elat);
            m_hi = eh; m_lo = el;
            repeat ($urandom_range(0, 2)) tick;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
